// File: rtl/icache_line_fill_if.sv
// Signal bundle between the line-fill stage, the fetch controller, the memory
// bus and the icache data array. The fill stage uses the slave modport.
interface icache_line_fill_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int SET_BITS   = 4,
  parameter int LINE_BITS  = 256,
  parameter int BEAT_BITS  = 64
);
  logic                     miss_valid;
  logic                     miss_ready;
  logic [ADDR_WIDTH-1:0]    miss_addr;
  logic                     kill;
  logic [ADDR_WIDTH-1:0]    bmem_addr;
  logic                     bmem_read;
  logic                     bmem_ready;
  logic [ADDR_WIDTH-1:0]    bmem_raddr;
  logic [BEAT_BITS-1:0]     bmem_rdata;
  logic                     bmem_rvalid;
  logic                     data_csb;
  logic                     data_web;
  logic [LINE_BITS/8-1:0]   data_wmask;
  logic [SET_BITS-1:0]      data_addr;
  logic [LINE_BITS-1:0]     data_din;
  logic                     fill_valid;
  logic [ADDR_WIDTH-1:0]    fill_addr;
  logic [LINE_BITS-1:0]     fill_line;

  modport slave (
    input  miss_valid, miss_addr, kill, bmem_ready, bmem_raddr, bmem_rdata, bmem_rvalid,
    output miss_ready, bmem_addr, bmem_read, data_csb, data_web, data_wmask, data_addr,
           data_din, fill_valid, fill_addr, fill_line
  );

  modport master (
    output miss_valid, miss_addr, kill, bmem_ready, bmem_raddr, bmem_rdata, bmem_rvalid,
    input  miss_ready, bmem_addr, bmem_read, data_csb, data_web, data_wmask, data_addr,
           data_din, fill_valid, fill_addr, fill_line
  );
endinterface

// File: rtl/icache_line_fill.sv
// Icache miss refill: burst-reads one line from memory, writes it into the
// data array with a full byte mask, then pulses fill_valid unless killed.
module icache_line_fill #(
  parameter int ADDR_WIDTH = 32,
  parameter int SET_BITS   = 4,
  parameter int LINE_BITS  = 256,
  parameter int BEAT_BITS  = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  icache_line_fill_if.slave  bus
);
  localparam int BEATS       = LINE_BITS / BEAT_BITS;
  localparam int OFFSET_BITS = $clog2(LINE_BITS / 8);
  localparam int CNT_BITS    = $clog2(BEATS);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_REQ     = 3'd1,
    S_COLLECT = 3'd2,
    S_WRITE   = 3'd3,
    S_COMMIT  = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [CNT_BITS-1:0]   cnt_q, cnt_d;
  logic                  kill_q, kill_d;
  logic [LINE_BITS-1:0]  line_q, line_d;
  logic                  beat_hit_s;

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      kill_q  <= 1'b0;
      line_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      kill_q  <= kill_d;
      line_q  <= line_d;
    end
  end

  assign beat_hit_s = bus.bmem_rvalid && (bus.bmem_raddr == addr_q);

  // Next-state logic; a kill after the handshake only suppresses the response
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    kill_d  = kill_q;
    line_d  = line_q;
    case (state_q)
      S_IDLE: begin
        if (bus.miss_valid) begin
          addr_d  = {bus.miss_addr[ADDR_WIDTH-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
          kill_d  = 1'b0;
          state_d = S_REQ;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_REQ: begin
        if (bus.bmem_ready) begin
          cnt_d   = '0;
          kill_d  = bus.kill;
          state_d = S_COLLECT;
        end else if (bus.kill) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_REQ;
        end
      end
      S_COLLECT: begin
        if (bus.kill) begin
          kill_d = 1'b1;
        end else begin
          kill_d = kill_q;
        end
        if (beat_hit_s) begin
          line_d[cnt_q*BEAT_BITS +: BEAT_BITS] = bus.bmem_rdata;
          cnt_d = cnt_q + CNT_BITS'(1);
          if (cnt_q == CNT_BITS'(BEATS - 1)) begin
            state_d = S_WRITE;
          end else begin
            state_d = S_COLLECT;
          end
        end else begin
          state_d = S_COLLECT;
        end
      end
      S_WRITE: begin
        if (bus.kill) begin
          kill_d = 1'b1;
        end else begin
          kill_d = kill_q;
        end
        state_d = S_COMMIT;
      end
      S_COMMIT: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.miss_ready = (state_q == S_IDLE);
  assign bus.bmem_read  = (state_q == S_REQ);
  assign bus.bmem_addr  = addr_q;
  assign bus.data_csb   = (state_q != S_WRITE);
  assign bus.data_web   = (state_q != S_WRITE);
  assign bus.data_wmask = {(LINE_BITS/8){state_q == S_WRITE}};
  assign bus.data_addr  = addr_q[OFFSET_BITS+SET_BITS-1:OFFSET_BITS];
  assign bus.data_din   = line_q;
  assign bus.fill_valid = (state_q == S_COMMIT) && !kill_q;
  assign bus.fill_addr  = addr_q;
  assign bus.fill_line  = line_q;
endmodule

// File: doc/icache_line_fill.md
Name: icache_line_fill

Overview:
- Miss-refill stage directly upstream of the icache data array (16 sets × 256-bit lines, byte write mask, inputs registered on clock edge, read data valid the cycle after address capture).
- Accepts one line-miss request from the fetch-side icache controller, issues a burst read to the memory bus, and assembles four 64-bit beats into one 256-bit line.
- Writes the line into the data array with a full byte mask, then pulses a fill-complete response back to fetch.

Parameters:
- ADDR_WIDTH, 32, byte address width.
- SET_BITS, 4, data-array index width.
- LINE_BITS, 256, cache line width.
- BEAT_BITS, 64, memory burst beat width (BEATS = LINE_BITS/BEAT_BITS = 4; OFFSET_BITS = 5).

Ports:
- clk in 1: single clock.
- rst_n in 1: asynchronous, active-low reset.
- miss_valid in 1: miss request valid.
- miss_ready out 1: stage can accept a miss.
- miss_addr in ADDR_WIDTH: missing byte address.
- kill in 1: fetch redirect; suppresses response of the outstanding fill.
- bmem_addr out ADDR_WIDTH: line-aligned burst address.
- bmem_read out 1: burst read request.
- bmem_ready in 1: bus accepts the request this cycle.
- bmem_raddr in ADDR_WIDTH: address tag of returning beat.
- bmem_rdata in BEAT_BITS: returning beat data.
- bmem_rvalid in 1: beat valid.
- data_csb out 1: data array chip select, active low.
- data_web out 1: data array write enable, active low.
- data_wmask out LINE_BITS/8: byte write mask.
- data_addr out SET_BITS: set index.
- data_din out LINE_BITS: write data.
- fill_valid out 1: one-cycle fill-complete pulse.
- fill_addr out ADDR_WIDTH: line-aligned address of the completed fill.
- fill_line out LINE_BITS: completed line data.

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE; beat counter 0; kill flag 0; line buffer 0.
  - Outputs: miss_ready=1, bmem_read=0, bmem_addr=0, data_csb=1, data_web=1, data_wmask=0, data_addr=0, fill_valid=0.
  - Reset mid-operation abandons the burst immediately. Late beats arriving after reset are ignored in IDLE.
- FSM states: IDLE, REQ, COLLECT, WRITE, COMMIT.
- IDLE:
  - miss_ready=1.
  - On miss_valid: latch miss_addr with low OFFSET_BITS cleared, clear kill flag, go to REQ.
  - kill in IDLE has no effect.
- REQ:
  - bmem_read=1, bmem_addr=latched line address; both held stable until bmem_ready=1 is sampled.
  - Handshake cycle: go to COLLECT, beat counter = 0.
  - kill in REQ before the handshake completes: return to IDLE next cycle with no write and no fill_valid.
  - kill in the same cycle as bmem_ready: treated as kill during COLLECT.
- COLLECT:
  - A beat is consumed only when bmem_rvalid=1 and bmem_raddr equals the latched line address; other beats are dropped.
  - Beat n lands in line bits [64n+63:64n]; counter increments by 1.
  - On the 4th consumed beat, go to WRITE.
  - kill sets the sticky kill flag; the burst is always drained.
- WRITE (one cycle):
  - data_csb=0, data_web=0, data_wmask=all ones.
  - data_addr = line address bits [OFFSET_BITS+SET_BITS-1:OFFSET_BITS].
  - data_din = assembled line.
  - Go to COMMIT. The array is written even when killed, since the line data is correct.
- COMMIT (one cycle):
  - data_csb=1, data_web=1; the array performs its internal write at this cycle's closing edge.
  - fill_valid = !kill_flag, with fill_addr and fill_line driven from the latched line.
  - A data-array read issued in this cycle or later returns the new line.
  - Go to IDLE.
- Outside WRITE: data_csb=1, data_web=1, data_wmask=0. data_din and data_addr may hold the buffer contents.
- Only one miss is outstanding at a time. Minimum miss-to-fill_valid latency with bmem_ready and beats back-to-back: 7 cycles (IDLE accept, REQ, 4× COLLECT, WRITE, COMMIT pulse).
- fill_valid is never asserted in consecutive cycles.

Test Plan:
- Basic fill: miss_addr=0x0000_1234, bmem_ready=1 on first REQ cycle, beats 0x1111…11, 0x2222…22, 0x3333…33, 0x4444…44 back-to-back -> bmem_addr=0x0000_1220; single WRITE cycle with data_addr=0x1, wmask=0xFFFF_FFFF, din={0x4444…,0x3333…,0x2222…,0x1111…}; fill_valid pulse with fill_addr=0x0000_1220; a following array read of set 1 returns that line.
- Bus backpressure: bmem_ready low for 5 cycles, beats separated by 3 idle cycles -> bmem_read/bmem_addr stable throughout; exactly one WRITE cycle; fill_valid 1 cycle after WRITE.
- Foreign beat: a beat with bmem_raddr=0x0000_2000 arrives mid-burst for line 0x0000_1220 -> beat ignored; counter unchanged; line contains only matching beats.
- Kill: kill in REQ before ready -> IDLE, no bmem handshake, no array write. kill during the 2nd beat -> array still written, fill_valid stays 0, miss_ready=1 the cycle after COMMIT.
- Reset: rst_n low after 2 beats -> immediately miss_ready=1, data_csb=1, bmem_read=0. A new miss to 0x0000_3000 then completes correctly with no stale beats.
- Back-to-back: miss_valid held high with two addresses -> second miss accepted only in the IDLE cycle following COMMIT; writes target sets in order.
